fpga_bd_tx: RTL and testbench

- Synthesizable FPGA-side transmitter for the pin-to-core (P2C) link into the BD chip.
- Accepts 21-bit words from FPGA fabric on a valid/ready interface and buffers them in a small FIFO.
- Drives each word to BD with a 4-phase req/xe handshake: req asserted with data stable, BD drops xe to acknowledge, req released, BD re-raises xe.
- Sits between the FPGA routing/packetizer logic and the BD P2C pins.

---
 rtl/fpga_bd_tx.sv | 108 ++++++++++
 tb/tb_fpga_bd_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_bd_tx.sv
// FPGA-side P2C transmitter: small input FIFO feeding a 4-phase req/xe handshake into BD.
// Optional macro FPGA_BD_TX_XE_SYNC_EN adds a 2-flop synchronizer on bd_xe.
module fpga_bd_tx #(
  parameter int NUM_BITS   = 21,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                _Reset,
  input  logic [NUM_BITS-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_BITS-1:0] bd_data,
  output logic                bd_req,
  input  logic                bd_xe,
  output logic                busy,
  output logic [CNT_W-1:0]    words_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, SETUP, REQ, WAIT_XE} state_t;

  state_t              state, state_nxt;
  logic [NUM_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                empty, full, push, pop;
  logic                set_req, clr_req;
  logic                xe_s;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign busy     = !empty || (state == SETUP) || (state == REQ);

`ifdef FPGA_BD_TX_XE_SYNC_EN
  logic [1:0] xe_sync;

  always_ff @(posedge clk) begin
    if (!_Reset) xe_sync <= 2'b11;
    else         xe_sync <= {xe_sync[0], bd_xe};
  end

  assign xe_s = xe_sync[1];
`else
  assign xe_s = bd_xe;
`endif

  // Reset lands in WAIT_XE so a handshake cut short by reset finishes before the next req.
  always_ff @(posedge clk) begin
    if (!_Reset) state <= WAIT_XE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty && xe_s) state_nxt = SETUP;
      SETUP:   state_nxt = REQ;
      REQ:     if (!xe_s) state_nxt = WAIT_XE;
      WAIT_XE: if (xe_s)  state_nxt = IDLE;
      default: state_nxt = WAIT_XE;
    endcase
  end

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pop     = 1'b0;
    set_req = 1'b0;
    clr_req = 1'b0;
    case (state)
      IDLE:    pop     = !empty && xe_s;
      SETUP:   set_req = 1'b1;
      REQ:     clr_req = !xe_s;
      default: ;
    endcase
  end

  // NOTE: storage array has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (_Reset && push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      bd_data    <= '0;
      bd_req     <= 1'b0;
      words_sent <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        bd_data <= mem[rd_ptr[AW-1:0]];
      end
      if (set_req) bd_req <= 1'b1;
      else if (clr_req) bd_req <= 1'b0;
      if (clr_req) words_sent <= words_sent + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fpga_bd_tx.sv
// Directed bench for fpga_bd_tx: reset, single word, backpressure, streaming, reset mid-transfer, counter wrap.
module tb_fpga_bd_tx;

  localparam int NB = 21;
  localparam int BD_HOLD    = 0;
  localparam int BD_DELAY   = 1;
  localparam int BD_INSTANT = 2;
  localparam int LIMIT      = 400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] in_data;
  logic          in_valid;
  logic          in_ready, in_ready_w;
  logic [NB-1:0] bd_data, bd_data_w;
  logic          bd_req, bd_req_w;
  logic          bd_xe;
  logic          busy, busy_w;
  logic [31:0]   words_sent;
  logic [3:0]    words_sent_w;

  int checks_total  = 0;
  int checks_passed = 0;
  int bd_mode = BD_HOLD;
  int dly = 0;
  int cyc = 0;
  logic          prev_req = 1'b0;
  logic [NB-1:0] seen_data [$];
  int            seen_cyc  [$];
  logic [NB-1:0] exp_data  [$];

  fpga_bd_tx dut (
    .clk(clk), ._Reset(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bd_data(bd_data), .bd_req(bd_req), .bd_xe(bd_xe), .busy(busy), .words_sent(words_sent)
  );

  fpga_bd_tx #(.CNT_W(4)) dut_w (
    .clk(clk), ._Reset(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_w),
    .bd_data(bd_data_w), .bd_req(bd_req_w), .bd_xe(bd_xe), .busy(busy_w), .words_sent(words_sent_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // BD model and req monitor run on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (bd_req && !prev_req) begin
      seen_data.push_back(bd_data);
      seen_cyc.push_back(cyc);
    end
    prev_req = bd_req;
    if (bd_mode == BD_INSTANT) begin
      bd_xe = !bd_req;
    end else if (bd_mode == BD_DELAY) begin
      if (bd_req == bd_xe) begin
        dly++;
        if (dly >= 2) begin
          bd_xe = !bd_req;
          dly = 0;
        end
      end else begin
        dly = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [NB-1:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check("push_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    exp_data.push_back(d);
  endtask

  task automatic wait_sent(input logic [31:0] target);
    int n = 0;
    while (words_sent != target && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check("wait_sent_timeout", words_sent, target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    seen_data.delete();
    seen_cyc.delete();
    exp_data.delete();
  endtask

  task automatic check_seen(input string tag);
    check({tag, "_count"}, seen_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < seen_data.size(); i++)
      check(tag, seen_data[i], exp_data[i]);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    bd_xe    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset then idle
    cycles(3);
    check("rst_req", bd_req, 0);
    check("rst_data", bd_data, 0);
    check("rst_ready", in_ready, 1);
    check("rst_sent", words_sent, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    cycles(2);

    // Single word: latency N+1 for data, N+2 for req
    bd_mode  = BD_DELAY;
    in_data  = 21'h1ABCD;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("single_data_n1", bd_data, 21'h1ABCD);
    check("single_req_n1", bd_req, 0);
    @(posedge clk);
    #1;
    check("single_req_n2", bd_req, 1);
    wait_sent(1);
    check("single_req_off", bd_req, 0);
    cycles(4);
    check("single_sent", words_sent, 1);
    check("single_busy", busy, 0);

    // Backpressure: xe held low fills the FIFO without issuing
    seen_data.delete();
    seen_cyc.delete();
    exp_data.delete();
    bd_mode = BD_HOLD;
    bd_xe   = 1'b0;
    cycles(2);
    push(21'h00011);
    push(21'h00022);
    push(21'h00033);
    push(21'h00044);
    check("bp_ready_full", in_ready, 0);
    check("bp_busy", busy, 1);
    cycles(5);
    check("bp_no_req", bd_req, 0);
    check("bp_ready_still", in_ready, 0);
    bd_mode = BD_DELAY;
    bd_xe   = 1'b1;
    push(21'h1FFFF);
    wait_sent(6);
    check("bp_sent", words_sent, 6);
    check_seen("bp_order");

    // Back-to-back with instant responder, 16 words then one more for the 4-bit wrap
    do_reset();
    bd_mode = BD_INSTANT;
    for (int i = 0; i < 16; i++) push(NB'(21'h10000 + i * 21'h00131));
    wait_sent(16);
    cycles(2);
    check("b2b_sent16", words_sent, 16);
    check("wrap_sent16", words_sent_w, 0);
    check_seen("b2b_data");
    for (int i = 1; i < seen_cyc.size(); i++)
      check("b2b_spacing", seen_cyc[i] - seen_cyc[i-1], 4);
    push(21'h0BEEF);
    wait_sent(17);
    cycles(2);
    check("b2b_sent17", words_sent, 17);
    check("wrap_sent17", words_sent_w, 1);

    // Reset mid-transfer with xe high, then recovery gated by xe
    bd_mode = BD_HOLD;
    bd_xe   = 1'b1;
    push(21'h12345);
    push(21'h0AAAA);
    n = 0;
    while (!bd_req && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("mid_req_seen", bd_req, 1);
    push(21'h05555);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_req_drop", bd_req, 0);
    check("mid_ready", in_ready, 1);
    check("mid_busy", busy, 0);
    check("mid_sent_clr", words_sent, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bd_xe = 1'b0;
    seen_data.delete();
    seen_cyc.delete();
    exp_data.delete();
    push(21'h0C0DE);
    cycles(6);
    check("mid_hold_req", bd_req, 0);
    check("mid_hold_sent", words_sent, 0);
    bd_mode = BD_DELAY;
    bd_xe   = 1'b1;
    wait_sent(1);
    cycles(4);
    check("mid_resume_sent", words_sent, 1);
    check_seen("mid_resume_data");
    check("mid_resume_busy", busy, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
